ex_pipe_ctrl: RTL and testbench

- Sequences the single-issue execute stage: accepts decoded instructions from ID, decides when the ID/EX pipeline register loads, and tracks the instruction held in EX.
- Holds load/store instructions for a memory handshake, and stalls ID on read-after-write hazards (no forwarding in this revision).
- Raises PC redirect and IF flush on taken branches and jumps.
- Sits between the decoder, the execute ALU (it consumes the ALU's branch decision), the data-memory port and the register-file write port.

---
 rtl/ex_pipe_ctrl_pkg.sv | 33 +++
 rtl/ex_hazard_unit.sv | 32 +++
 rtl/ex_pipe_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ex_pipe_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_pipe_ctrl_pkg.sv
// Shared opcode constants and opcode-class helpers for the execute-stage controller.
package ex_pipe_ctrl_pkg;

    localparam logic [6:0] opcode_R       = 7'b0110011;
    localparam logic [6:0] opcode_I_lg    = 7'b0010011;
    localparam logic [6:0] opcode_I_ld    = 7'b0000011;
    localparam logic [6:0] opcode_S       = 7'b0100011;
    localparam logic [6:0] opcode_B       = 7'b1100011;
    localparam logic [6:0] opcode_U_lui   = 7'b0110111;
    localparam logic [6:0] opcode_U_auipc = 7'b0010111;
    localparam logic [6:0] opcode_J_jal   = 7'b1101111;
    localparam logic [6:0] opcode_J_jalr  = 7'b1100111;

    function automatic logic is_writer(input logic [6:0] op);
        return (op == opcode_R)      || (op == opcode_I_lg)    ||
               (op == opcode_I_ld)   || (op == opcode_U_lui)   ||
               (op == opcode_U_auipc)|| (op == opcode_J_jal)   ||
               (op == opcode_J_jalr);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == opcode_I_ld) || (op == opcode_S);
    endfunction

    function automatic logic is_jump(input logic [6:0] op);
        return (op == opcode_J_jal) || (op == opcode_J_jalr);
    endfunction

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == opcode_B) || is_jump(op);
    endfunction

endpackage

// File: rtl/ex_hazard_unit.sv
// Read-after-write comparator: flags an ID source register that matches the
// destination of the live EX instruction (no forwarding exists).
module ex_hazard_unit
    import ex_pipe_ctrl_pkg::*;
(
    input  logic       ex_valid,
    input  logic [6:0] ex_opcode,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    logic [4:0] src [2];
    logic [1:0] src_match;
    logic       ex_writes;

    assign src[0] = id_rs1;
    assign src[1] = id_rs2;

    // x0 is hardwired to zero, so a write to it can never create a dependency.
    assign ex_writes = ex_valid && is_writer(ex_opcode) && (ex_rd != 5'd0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = (src[gi] == ex_rd);
        end
    endgenerate

    assign hazard = ex_writes && (|src_match);

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage sequencer: ID/EX load control, memory handshake with timeout,
// RAW stall, and redirect/flush on taken control transfers.
module ex_pipe_ctrl
    import ex_pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       b_result,
    output logic       ex_load_en,
    output logic       ex_valid,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       wb_en,
    output logic       redirect,
    output logic       flush_if,
    output logic       mem_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    localparam logic [16:0] TMO_LIMIT  = 17'(MEM_TIMEOUT);
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [6:0]  ex_opcode_q, ex_opcode_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_valid_q, ex_valid_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        flush_if_q, flush_if_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        hazard;

    ex_hazard_unit u_hazard (
        .ex_valid  (ex_valid_q),
        .ex_opcode (ex_opcode_q),
        .ex_rd     (ex_rd_q),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .hazard    (hazard)
    );

    always_comb begin
        state_d       = state_q;
        ex_opcode_d   = ex_opcode_q;
        ex_rd_d       = ex_rd_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_timeout_d = mem_timeout_q;
        flush_if_d    = flush_if_q;
        tmo_cnt_d     = tmo_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        id_ready      = 1'b0;
        wb_en         = 1'b0;
        redirect      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                id_ready = 1'b1;
                if (id_valid) begin
                    ex_opcode_d = id_opcode;
                    ex_rd_d     = id_rd;
                    state_d     = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (is_mem(ex_opcode_q)) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = (ex_opcode_q == opcode_S);
                    tmo_cnt_d = 16'd0;
                    state_d   = ST_MEM_WAIT;
                end else if (is_ctl(ex_opcode_q)) begin
                    // b_result only matters for conditional branches; jumps always redirect.
                    if (is_jump(ex_opcode_q) || b_result) begin
                        redirect    = 1'b1;
                        wb_en       = is_jump(ex_opcode_q) && (ex_rd_q != 5'd0);
                        flush_if_d  = 1'b1;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    wb_en    = (ex_rd_q != 5'd0);
                    id_ready = !hazard;
                    if (id_valid && !hazard) begin
                        ex_opcode_d = id_opcode;
                        ex_rd_d     = id_rd;
                        state_d     = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    wb_en     = (ex_opcode_q == opcode_I_ld) && (ex_rd_q != 5'd0);
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end else if (({1'b0, tmo_cnt_q} + 17'd1) == TMO_LIMIT) begin
                    mem_timeout_d = 1'b1;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    flush_if_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // EX holds a live instruction while executing or waiting on memory.
        ex_valid_d = (state_d == ST_EXEC) || (state_d == ST_MEM_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ex_opcode_q   <= 7'd0;
            ex_rd_q       <= 5'd0;
            ex_valid_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
            flush_if_q    <= 1'b0;
            tmo_cnt_q     <= 16'd0;
            flush_cnt_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_rd_q       <= ex_rd_d;
            ex_valid_q    <= ex_valid_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_timeout_q <= mem_timeout_d;
            flush_if_q    <= flush_if_d;
            tmo_cnt_q     <= tmo_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign ex_load_en  = id_valid && id_ready;
    assign ex_valid    = ex_valid_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign flush_if    = flush_if_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Directed per-cycle vector table for ex_pipe_ctrl plus a hand-written async-reset sequence.
module tb_ex_pipe_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic       id_ready;
    logic [6:0] id_opcode = 7'd0;
    logic [4:0] id_rd = 5'd0;
    logic [4:0] id_rs1 = 5'd0;
    logic [4:0] id_rs2 = 5'd0;
    logic       b_result = 1'b0;
    logic       ex_load_en;
    logic       ex_valid;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack = 1'b0;
    logic       wb_en;
    logic       redirect;
    logic       flush_if;
    logic       mem_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_pipe_ctrl #(.MEM_TIMEOUT(4), .FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_opcode   (id_opcode),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .b_result    (b_result),
        .ex_load_en  (ex_load_en),
        .ex_valid    (ex_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .wb_en       (wb_en),
        .redirect    (redirect),
        .flush_if    (flush_if),
        .mem_timeout (mem_timeout)
    );

    // exp bits: {id_ready, wb_en, redirect, flush_if, mem_req, mem_we, ex_valid, mem_timeout}
    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       b;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic b, input logic ack, input logic [7:0] exp);
        vec_t t;
        t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.b = b; t.ack = ack; t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic b, input logic ack);
        id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        b_result = b; mem_ack = ack;
    endtask

    initial begin
        // Test 1: RAW stall on rs1, x0 never hazards, RAW stall on rs2 behind lui
        add(1, OP_R,   3, 1, 2, 0, 0, 8'b1000_0000);
        add(1, OP_R,   4, 3, 0, 0, 0, 8'b0100_0010);
        add(1, OP_R,   4, 3, 0, 0, 0, 8'b1000_0000);
        add(1, OP_R,   5, 1, 2, 0, 0, 8'b1100_0010);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b1100_0010);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b1000_0000);
        add(1, OP_R,   0, 1, 2, 0, 0, 8'b1000_0000);
        add(1, OP_R,   6, 0, 0, 0, 0, 8'b1000_0010);
        add(1, OP_LUI, 7, 0, 0, 0, 0, 8'b1100_0010);
        add(1, OP_R,   8, 1, 7, 0, 0, 8'b0100_0010);
        add(1, OP_R,   8, 1, 7, 0, 0, 8'b1000_0000);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b1100_0010);
        // Test 2: lw x5, ack on third mem_req cycle; ack outside MEM_WAIT ignored
        add(1, OP_LD,  5, 1, 0, 0, 0, 8'b1000_0000);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b0000_0010);
        add(1, OP_R,   9, 1, 2, 0, 0, 8'b0000_1010);
        add(1, OP_R,   9, 1, 2, 0, 0, 8'b0000_1010);
        add(1, OP_R,   9, 1, 2, 0, 1, 8'b0100_1010);
        add(1, OP_R,   9, 1, 2, 0, 0, 8'b1000_0000);
        add(0, OP_R,   0, 0, 0, 0, 1, 8'b1100_0010);
        // Test 3: sw with no ack, timeout after 4 cycles, flag is sticky from here on
        add(1, OP_S,   5, 1, 2, 0, 0, 8'b1000_0000);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b0000_0010);
        for (int i = 0; i < 4; i++) add(0, OP_R, 0, 0, 0, 0, 0, 8'b0000_1110);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b1000_0001);
        // Test 4: beq taken with id_valid held, then beq not taken
        add(1, OP_B,   0, 1, 2, 0, 0, 8'b1000_0001);
        add(1, OP_R,  10, 1, 2, 1, 0, 8'b0010_0011);
        add(1, OP_R,  10, 1, 2, 0, 0, 8'b0001_0001);
        add(1, OP_R,  10, 1, 2, 0, 0, 8'b0001_0001);
        add(1, OP_R,  10, 1, 2, 0, 0, 8'b1000_0001);
        add(1, OP_B,   0, 1, 2, 0, 0, 8'b1100_0011);
        add(1, OP_R,  11, 1, 2, 0, 0, 8'b0000_0011);
        add(1, OP_R,  11, 1, 2, 0, 0, 8'b1000_0001);
        // Test 5: jal x1 writes back, jal x0 does not
        add(1, OP_JAL, 1, 0, 0, 0, 0, 8'b1100_0011);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b0110_0011);
        add(1, OP_JAL, 0, 0, 0, 0, 0, 8'b0001_0001);
        add(1, OP_JAL, 0, 0, 0, 0, 0, 8'b0001_0001);
        add(1, OP_JAL, 0, 0, 0, 0, 0, 8'b1000_0001);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b0010_0011);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b0001_0001);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b0001_0001);
        add(0, OP_R,   0, 0, 0, 0, 0, 8'b1000_0001);

        // Reset state while rst_n is held low
        repeat (2) @(posedge clk);
        #4;
        chk("rst_id_ready", -1, id_ready, 1'b1);
        chk("rst_ex_valid", -1, ex_valid, 1'b0);
        chk("rst_mem_req", -1, mem_req, 1'b0);
        chk("rst_mem_we", -1, mem_we, 1'b0);
        chk("rst_wb_en", -1, wb_en, 1'b0);
        chk("rst_redirect", -1, redirect, 1'b0);
        chk("rst_flush_if", -1, flush_if, 1'b0);
        chk("rst_mem_timeout", -1, mem_timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].b, vecs[i].ack);
            #3;
            chk("id_ready",    i, id_ready,    vecs[i].exp[7]);
            chk("ex_load_en",  i, ex_load_en,  vecs[i].v & vecs[i].exp[7]);
            chk("wb_en",       i, wb_en,       vecs[i].exp[6]);
            chk("redirect",    i, redirect,    vecs[i].exp[5]);
            chk("flush_if",    i, flush_if,    vecs[i].exp[4]);
            chk("mem_req",     i, mem_req,     vecs[i].exp[3]);
            chk("mem_we",      i, mem_we,      vecs[i].exp[2]);
            chk("ex_valid",    i, ex_valid,    vecs[i].exp[1]);
            chk("mem_timeout", i, mem_timeout, vecs[i].exp[0]);
            $display("step %0d v=%b op=%b rd=%0d rs=%0d/%0d b=%b ack=%b -> rdy=%b wb=%b rdr=%b fl=%b req=%b we=%b exv=%b tmo=%b",
                     i, vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].b, vecs[i].ack,
                     id_ready, wb_en, redirect, flush_if, mem_req, mem_we, ex_valid, mem_timeout);
        end

        // Test 6: asynchronous reset in the second MEM_WAIT cycle
        @(posedge clk); #1;
        drive(1, OP_LD, 5, 1, 0, 0, 0);
        #3;
        chk("t6_accept", 100, ex_load_en, 1'b1);
        @(posedge clk); #1;
        drive(0, OP_R, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t6_req_c1", 101, mem_req, 1'b1);
        @(posedge clk); #1;
        chk("t6_req_c2", 102, mem_req, 1'b1);
        chk("t6_exv_c2", 102, ex_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_req_async", 103, mem_req, 1'b0);
        chk("t6_exv_async", 103, ex_valid, 1'b0);
        chk("t6_tmo_async", 103, mem_timeout, 1'b0);
        chk("t6_rdy_async", 103, id_ready, 1'b1);
        $display("step 103 async reset in MEM_WAIT -> req=%b exv=%b tmo=%b", mem_req, ex_valid, mem_timeout);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #4;
        chk("t6_rdy_after", 104, id_ready, 1'b1);
        chk("t6_exv_after", 104, ex_valid, 1'b0);
        chk("t6_req_after", 104, mem_req, 1'b0);
        @(posedge clk); #1;
        drive(1, OP_R, 3, 1, 2, 0, 0);
        #3;
        chk("t6_accept_after", 105, ex_load_en, 1'b1);
        @(posedge clk); #1;
        drive(0, OP_R, 0, 0, 0, 0, 0);
        #3;
        chk("t6_exv_new", 106, ex_valid, 1'b1);
        chk("t6_wb_new", 106, wb_en, 1'b1);
        $display("step 106 after reset release -> exv=%b wb=%b", ex_valid, wb_en);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
